// File: rtl/r4mdc_pkg.sv
// Shared definitions for the R4MDC input commutator.
//   WL_DEFAULT : default real/imag component width
//   NLANES     : number of parallel output lanes (radix 4)
//   clog2      : ceiling log2, usable in parameter expressions
//   idx_width  : width of the frame sample index for a given segment depth
package r4mdc_pkg;

  localparam int WL_DEFAULT = 16;
  localparam int NLANES     = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index spans one whole frame (NLANES*depth samples); never narrower than
  // the 2-bit segment field it carries in its top bits.
  function automatic int idx_width(input int depth);
    int w;
    w = clog2(NLANES * depth);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/r4mdc_lane_buf.sv
// Segment buffer for one commutator lane: DEPTH entries of packed {re, im}.
// Synchronous write, asynchronous read. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address (sample position within the segment)
//   i_wdata : write data {re, im}
//   i_raddr : read address
//   o_rdata : read data {re, im}
module r4mdc_lane_buf #(
  parameter int WL    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [2*WL-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [2*WL-1:0] o_rdata
);

  if (DEPTH > 1) begin : g_array
    logic [2*WL-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
  end else begin : g_single
    // A one-entry segment needs no addressing at all.
    logic [2*WL-1:0] r_word;
    logic            w_unused_addr;

    always_ff @(posedge i_clk) begin
      if (i_we) r_word <= i_wdata;
    end

    assign o_rdata       = r_word;
    assign w_unused_addr = ^{i_waddr, i_raddr};
  end

endmodule

// File: rtl/r4mdc_input_commutator.sv
// Radix-4 MDC input commutator. Converts one serial complex stream into four
// time-aligned lanes: lane k carries sample k*DEPTH + p of each frame.
// Segments 0..2 are parked in lane buffers; each segment-3 sample releases a
// registered quadruple one clock later.
//   clk, rst            : clock, async active-high reset
//   in_r, in_i          : serial input sample (re, im)
//   in_valid            : sample accepted on this edge
//   flush               : synchronous frame abort (drops the sample on this edge)
//   out0..3_r/_i        : lane outputs, hold value between quadruples
//   out_valid           : aligned quadruple present
//   frame_start         : first quadruple of a frame (p = 0)
//   seg                 : segment of the next sample to be accepted
module r4mdc_input_commutator
  import r4mdc_pkg::*;
#(
  parameter int WL    = WL_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] in_r,
  input  logic [WL-1:0] in_i,
  input  logic          in_valid,
  input  logic          flush,
  output logic [WL-1:0] out0_r,
  output logic [WL-1:0] out0_i,
  output logic [WL-1:0] out1_r,
  output logic [WL-1:0] out1_i,
  output logic [WL-1:0] out2_r,
  output logic [WL-1:0] out2_i,
  output logic [WL-1:0] out3_r,
  output logic [WL-1:0] out3_i,
  output logic          out_valid,
  output logic          frame_start,
  output logic [1:0]    seg
);

  localparam int IW = idx_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NLANES * DEPTH - 1);

  logic [IW-1:0]   r_idx;
  logic [1:0]      w_seg;
  logic [AW-1:0]   w_p;
  logic            w_accept;
  logic            w_emit;
  logic [2*WL-1:0] w_rd [NLANES-1];

  logic [WL-1:0]   r_out0_r, r_out0_i, r_out1_r, r_out1_i;
  logic [WL-1:0]   r_out2_r, r_out2_i, r_out3_r, r_out3_i;
  logic            r_out_valid;
  logic            r_frame_start;

  // DEPTH is a power of two, so seg is the top two index bits and p the rest.
  assign w_seg = r_idx[IW-1 -: 2];

  if (DEPTH > 1) begin : g_p
    assign w_p = r_idx[AW-1:0];
  end else begin : g_p1
    assign w_p = '0;
  end

  assign w_accept = in_valid & ~flush;
  assign w_emit   = w_accept & (w_seg == 2'd3);

  for (genvar k = 0; k < NLANES - 1; k++) begin : g_lane
    logic w_we;
    assign w_we = w_accept & (w_seg == 2'(k));

    r4mdc_lane_buf #(
      .WL    (WL),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_buf (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (w_p),
      .i_wdata ({in_r, in_i}),
      .i_raddr (w_p),
      .o_rdata (w_rd[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (flush) begin
      r_idx <= '0;
    end else if (in_valid) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Data registers load only on a quadruple and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out0_r      <= '0;
      r_out0_i      <= '0;
      r_out1_r      <= '0;
      r_out1_i      <= '0;
      r_out2_r      <= '0;
      r_out2_i      <= '0;
      r_out3_r      <= '0;
      r_out3_i      <= '0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_out_valid   <= w_emit;
      r_frame_start <= w_emit & (w_p == '0);
      if (w_emit) begin
        {r_out0_r, r_out0_i} <= w_rd[0];
        {r_out1_r, r_out1_i} <= w_rd[1];
        {r_out2_r, r_out2_i} <= w_rd[2];
        r_out3_r             <= in_r;
        r_out3_i             <= in_i;
      end
    end
  end

  assign out0_r      = r_out0_r;
  assign out0_i      = r_out0_i;
  assign out1_r      = r_out1_r;
  assign out1_i      = r_out1_i;
  assign out2_r      = r_out2_r;
  assign out2_i      = r_out2_i;
  assign out3_r      = r_out3_r;
  assign out3_i      = r_out3_i;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign seg         = w_seg;

endmodule
